// File: rtl/counter_down_timer_pkg.sv
// Shared types and constants for the programmable down-counting timer.
package counter_down_timer_pkg;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_PRESCALE_W = 8;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider for the down timer: one tick every prescale+1 enabled cycles.
module timer_prescaler
  import counter_down_timer_pkg::*;
#(
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;
  logic                  wrap;

  // >= rather than == so lowering prescale mid-run never strands the counter above it
  assign wrap = (cnt >= prescale);
  assign tick = enable && !clear && wrap;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_down_timer.sv
// Loadable down timer with prescaler, one-shot/periodic modes and a registered tc pulse.
//   state | meaning
//   IDLE  | count holds, prescaler frozen, busy = 0
//   RUN   | prescaler counting, count decrements on each tick, busy = 1
module counter_down_timer
  import counter_down_timer_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      data,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  periodic,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  tc
);

  state_t           state, state_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] reload, reload_n;
  logic             mode, mode_n;
  logic             tc_n;
  logic             tick;
  logic             start_acc;

  assign start_acc = start && !stop;

  timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .enable  ((state == RUN) && !stop),
    .clear   (start_acc),
    .prescale(prescale),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      mode   <= MODE_ONESHOT;
      tc     <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      reload <= reload_n;
      mode   <= mode_n;
      tc     <= tc_n;
    end
  end

  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload;
    mode_n   = mode;
    tc_n     = 1'b0;
    if (stop) begin
      state_n = IDLE;
    end else begin
      if (load) begin
        count_n  = data;
        reload_n = data;
      end
      if (start_acc) begin
        state_n = RUN;
        mode_n  = periodic;
      end else if (tick && !load) begin
        if (count != '0) begin
          count_n = count - 1'b1;
        end else begin
          tc_n = 1'b1;
          if (mode == MODE_PERIODIC) begin
            count_n = reload;
          end else begin
            state_n = IDLE;
          end
        end
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_counter_down_timer.sv
// Self-checking bench for counter_down_timer: vector table plus hand-written long sequences.
module tb_counter_down_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [7:0] data = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       periodic = 1'b0;
  logic [7:0] prescale = '0;
  logic [7:0] count;
  logic       busy;
  logic       tc;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic       load;
    logic [7:0] data;
    logic       start;
    logic       stop;
    logic       periodic;
    logic [7:0] prescale;
    logic [7:0] ec;
    logic       eb;
    logic       et;
  } vec_t;

  typedef struct {
    logic [7:0] ec;
    logic       eb;
    logic       et;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   step_no = 0;

  counter_down_timer dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .data    (data),
    .start   (start),
    .stop    (stop),
    .periodic(periodic),
    .prescale(prescale),
    .count   (count),
    .busy    (busy),
    .tc      (tc)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(logic r, logic l, logic [7:0] d, logic s, logic p, logic per,
                             logic [7:0] ps, logic [7:0] ec, logic eb, logic et);
    vec_t x;
    x.rst = r; x.load = l; x.data = d; x.start = s; x.stop = p; x.periodic = per;
    x.prescale = ps; x.ec = ec; x.eb = eb; x.et = et;
    return x;
  endfunction

  task automatic chk(string name, int idx, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s step=%0d actual=%0d required=%0d", name, idx, act, req);
    end
  endtask

  // Drive one cycle, push its expectation, then pop and compare after the edge.
  task automatic step(vec_t x);
    exp_t e;
    rst = x.rst; load = x.load; data = x.data; start = x.start;
    stop = x.stop; periodic = x.periodic; prescale = x.prescale;
    e.ec = x.ec; e.eb = x.eb; e.et = x.et; e.idx = step_no;
    sb.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("count", e.idx, int'(count), int'(e.ec));
    chk("busy",  e.idx, int'(busy),  int'(e.eb));
    chk("tc",    e.idx, int'(tc),    int'(e.et));
  endtask

  initial begin
    //        rst ld data st sp per ps   cnt busy tc
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0,  0, 0, 0));  // reset
    vecs.push_back(v(1, 1, 3, 0, 0, 0, 0,  3, 0, 0));  // one-shot from 3
    vecs.push_back(v(1, 0, 0, 1, 0, 0, 0,  3, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,  2, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,  1, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(v(1, 1, 2, 0, 0, 0, 1,  2, 0, 0));  // periodic, prescale 1
    vecs.push_back(v(1, 0, 0, 1, 0, 1, 1,  2, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1,  2, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1,  1, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1,  1, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1,  0, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1,  0, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1,  2, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1,  2, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1,  1, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1,  1, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1,  0, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1,  0, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1,  2, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 1, 0, 1,  2, 0, 0));  // stop
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 0,  0, 0, 0));  // periodic reload 0
    vecs.push_back(v(1, 0, 0, 1, 0, 1, 0,  0, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 1, 0, 0,  0, 0, 0));
    vecs.push_back(v(1, 0, 0, 1, 0, 0, 0,  0, 1, 0));  // start with count 0
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(v(1, 1, 1, 0, 0, 0, 0,  1, 0, 0));  // stop on expiring tick
    vecs.push_back(v(1, 0, 0, 1, 0, 0, 0,  1, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 1, 0, 0,  0, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(v(1, 1, 4, 1, 0, 0, 0,  4, 1, 0));  // load + start together
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,  3, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 1, 0, 0,  3, 0, 0));
    vecs.push_back(v(1, 1, 5, 1, 0, 0, 2,  5, 1, 0));  // load during run, prescale 2
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 2,  5, 1, 0));
    vecs.push_back(v(1, 1, 7, 0, 0, 0, 2,  7, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 2,  6, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 2,  6, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 2,  6, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 2,  5, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 2,  5, 1, 0));
    vecs.push_back(v(1, 0, 0, 1, 0, 1, 2,  5, 1, 0));  // restart mid-prescale, periodic
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 2,  5, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 2,  5, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 2,  4, 1, 0));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Restarted run is now periodic: count 4 down to 0, then tc with reload to 7.
    for (int k = 1; k <= 15; k++) begin
      if (k <= 12)      step(v(1, 0, 0, 0, 0, 0, 2, 8'(4 - k / 3), 1, 0));
      else if (k < 15)  step(v(1, 0, 0, 0, 0, 0, 2, 0, 1, 0));
      else              step(v(1, 0, 0, 0, 0, 0, 2, 7, 1, 1));
    end
    step(v(1, 0, 0, 0, 1, 0, 2, 7, 0, 0));

    // Reset in the middle of a run.
    step(v(1, 1, 5, 1, 0, 0, 0, 5, 1, 0));
    step(v(1, 0, 0, 0, 0, 0, 0, 4, 1, 0));
    step(v(1, 0, 0, 0, 0, 0, 0, 3, 1, 0));
    step(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++) step(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Full-range load: 256 ticks from start to tc.
    step(v(1, 1, 255, 1, 0, 0, 0, 255, 1, 0));
    for (int k = 1; k <= 255; k++) step(v(1, 0, 0, 0, 0, 0, 0, 8'(255 - k), 1, 0));
    step(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    chk("scoreboard_empty", step_no, sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
